// File: rtl/rv32_led_ctrl.sv
// rv32_led_ctrl
//   Memory-mapped LED controller. It is the responder on the priRV32 data bus
//   and holds a static LED pattern plus a prescaled blink engine. A free
//   running tick counter lets firmware measure elapsed blink periods.
//
//   Register window (byte offsets from BASE_ADDR, 16 bytes):
//     0x0 LED_DATA    RW  LED_WIDTH bits
//     0x4 BLINK_MASK  RW  LED_WIDTH bits
//     0x8 PRESCALE    RW  16 bits
//     0xC TICK_COUNT  RO  32 bits, any write clears it
//
//   Ports:
//     clk        system clock, rising edge
//     reset      asynchronous, active-high reset
//     bus_valid  request present, held with its fields until bus_ready
//     bus_we     1 = write, 0 = read
//     bus_addr   byte address
//     bus_wdata  write data
//     bus_wstrb  byte-lane enables for writes
//     bus_ready  one-cycle response strobe
//     bus_rdata  read data, valid while bus_ready
//     bus_err    error response, valid while bus_ready
//     led        registered LED drive
//
//   state | meaning
//   IDLE  | waiting for a request; a valid request executes on this edge
//   RESP  | bus_ready high for one cycle with the captured response

module rv32_led_ctrl #(
  parameter int          LED_WIDTH    = 8,
  parameter logic [31:0] BASE_ADDR    = 32'h1000_0000,
  parameter logic [15:0] PRESCALE_RST = 16'd50000
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 bus_valid,
  input  logic                 bus_we,
  input  logic [31:0]          bus_addr,
  input  logic [31:0]          bus_wdata,
  input  logic [3:0]           bus_wstrb,
  output logic                 bus_ready,
  output logic [31:0]          bus_rdata,
  output logic                 bus_err,
  output logic [LED_WIDTH-1:0] led
);

  typedef enum logic {ST_IDLE, ST_RESP} state_t;

  state_t r_state, w_state_nxt;

  logic [LED_WIDTH-1:0] r_led_data, r_blink_mask, r_led;
  logic [15:0]          r_prescale, r_cnt;
  logic                 r_phase;
  logic [31:0]          r_tick_count;
  logic [31:0]          r_rdata;
  logic                 r_err;

  logic [31:0]          w_off;
  logic                 w_req, w_err, w_wr;
  logic                 w_wr_led, w_wr_mask, w_wr_ps, w_wr_tick;
  logic [31:0]          w_strb_mask;
  logic [31:0]          w_rd_val;
  logic                 w_tick;
  logic [LED_WIDTH-1:0] w_led_data_nxt, w_blink_mask_nxt, w_led_nxt;
  logic [15:0]          w_prescale_nxt, w_cnt_nxt;
  logic                 w_phase_nxt;
  logic [31:0]          w_tick_nxt;

  function automatic logic [31:0] merge(input logic [31:0] old_v,
                                        input logic [31:0] new_v,
                                        input logic [31:0] mask);
    return (old_v & ~mask) | (new_v & mask);
  endfunction

  // Subtracting the base lets one unsigned compare cover both window edges.
  assign w_off       = bus_addr - BASE_ADDR;
  assign w_req       = (r_state == ST_IDLE) && bus_valid;
  assign w_err       = (w_off >= 32'd16) || (bus_addr[1:0] != 2'b00) ||
                       (bus_we && (bus_wstrb == 4'b0000));
  assign w_wr        = w_req && bus_we && !w_err;
  assign w_wr_led    = w_wr && (w_off[3:2] == 2'd0);
  assign w_wr_mask   = w_wr && (w_off[3:2] == 2'd1);
  assign w_wr_ps     = w_wr && (w_off[3:2] == 2'd2);
  assign w_wr_tick   = w_wr && (w_off[3:2] == 2'd3);
  assign w_strb_mask = {{8{bus_wstrb[3]}}, {8{bus_wstrb[2]}},
                        {8{bus_wstrb[1]}}, {8{bus_wstrb[0]}}};

  // A PRESCALE write on a wrap edge suppresses that edge's tick.
  assign w_tick = (r_prescale != 16'd0) && (r_cnt == 16'd0) && !w_wr_ps;

  always_comb begin
    w_led_data_nxt   = r_led_data;
    w_blink_mask_nxt = r_blink_mask;
    w_prescale_nxt   = r_prescale;
    w_cnt_nxt        = r_cnt;
    w_phase_nxt      = r_phase;
    w_tick_nxt       = r_tick_count;
    w_rd_val         = 32'd0;

    if (w_wr_led)
      w_led_data_nxt = LED_WIDTH'(merge(32'(r_led_data), bus_wdata, w_strb_mask));
    if (w_wr_mask)
      w_blink_mask_nxt = LED_WIDTH'(merge(32'(r_blink_mask), bus_wdata, w_strb_mask));
    if (w_wr_ps)
      w_prescale_nxt = 16'(merge(32'(r_prescale), bus_wdata, w_strb_mask));

    if (w_wr_ps) begin
      w_cnt_nxt   = w_prescale_nxt;
      w_phase_nxt = 1'b0;
    end else if (r_prescale != 16'd0) begin
      if (r_cnt == 16'd0) begin
        w_cnt_nxt   = r_prescale;
        w_phase_nxt = ~r_phase;
      end else begin
        w_cnt_nxt   = r_cnt - 16'd1;
      end
    end

    if (w_wr_tick)
      w_tick_nxt = 32'd0;
    else if (w_tick)
      w_tick_nxt = r_tick_count + 32'd1;

    if (w_req && !w_err && !bus_we) begin
      case (w_off[3:2])
        2'd0:    w_rd_val = 32'(r_led_data);
        2'd1:    w_rd_val = 32'(r_blink_mask);
        2'd2:    w_rd_val = 32'(r_prescale);
        default: w_rd_val = r_tick_count;
      endcase
    end
  end

  assign w_led_nxt = w_led_data_nxt ^ (w_blink_mask_nxt & {LED_WIDTH{w_phase_nxt}});

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: if (bus_valid) w_state_nxt = ST_RESP;
      ST_RESP: w_state_nxt = ST_IDLE;
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state      <= ST_IDLE;
      r_led_data   <= '0;
      r_blink_mask <= '0;
      r_prescale   <= PRESCALE_RST;
      r_cnt        <= PRESCALE_RST;
      r_phase      <= 1'b0;
      r_tick_count <= 32'd0;
      r_led        <= '0;
      r_rdata      <= 32'd0;
      r_err        <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_led_data   <= w_led_data_nxt;
      r_blink_mask <= w_blink_mask_nxt;
      r_prescale   <= w_prescale_nxt;
      r_cnt        <= w_cnt_nxt;
      r_phase      <= w_phase_nxt;
      r_tick_count <= w_tick_nxt;
      r_led        <= w_led_nxt;
      // Response fields live only for the RESP cycle and fall back to 0.
      r_rdata      <= w_rd_val;
      r_err        <= w_req && w_err;
    end
  end

  assign bus_ready = (r_state == ST_RESP);
  assign bus_rdata = r_rdata;
  assign bus_err   = r_err;
  assign led       = r_led;

endmodule

// File: tb/tb_rv32_led_ctrl.sv
module tb_rv32_led_ctrl;

  localparam logic [31:0] BASE = 32'h1000_0000;

  logic        clk = 1'b0;
  logic        reset;
  logic        bus_valid;
  logic        bus_we;
  logic [31:0] bus_addr;
  logic [31:0] bus_wdata;
  logic [3:0]  bus_wstrb;
  logic        bus_ready;
  logic [31:0] bus_rdata;
  logic        bus_err;
  logic [7:0]  led;

  rv32_led_ctrl dut (
    .clk       (clk),
    .reset     (reset),
    .bus_valid (bus_valid),
    .bus_we    (bus_we),
    .bus_addr  (bus_addr),
    .bus_wdata (bus_wdata),
    .bus_wstrb (bus_wstrb),
    .bus_ready (bus_ready),
    .bus_rdata (bus_rdata),
    .bus_err   (bus_err),
    .led       (led)
  );

  always #5 clk = ~clk;

  // Number of rising edges seen so far; at a falling edge it is the index of
  // the next rising edge.
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks   = 0;
  int failures = 0;
  int ntx      = 0;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          id;
  } exp_t;

  exp_t sb[$];

  // Reference model: register contents plus the blink timeline expressed as
  // "toggles since the last PRESCALE reference edge".
  logic [7:0]  m_ld, m_mask;
  logic [15:0] m_ps;
  longint      m_ref;
  logic [31:0] m_tbase;

  function automatic longint tog(input longint x);
    if (m_ps == 16'd0 || x < m_ref) return 0;
    return (x - m_ref) / (longint'(m_ps) + 1);
  endfunction

  function automatic logic [31:0] m_tick_pre(input longint e);
    return m_tbase + 32'(tog(e - 1));
  endfunction

  function automatic logic [7:0] m_led(input longint e);
    longint t;
    logic   ph;
    t  = tog(e);
    ph = t[0];
    return m_ld ^ (m_mask & {8{ph}});
  endfunction

  task automatic m_reset();
    m_ld    = 8'h00;
    m_mask  = 8'h00;
    m_ps    = 16'd50000;
    m_tbase = 32'd0;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s got=%h want=%h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic chk_led();
    chk("led", 32'(led), 32'(m_led(longint'(cyc) - 1)));
  endtask

  // Response monitor: pops the scoreboard whenever the DUT presents a response.
  always @(negedge clk) begin : mon
    exp_t e;
    if (bus_ready === 1'b1) begin
      checks++;
      if (sb.size() == 0) begin
        failures++;
        $display("FAIL unexpected_resp got rdata=%h err=%b want no response", bus_rdata, bus_err);
      end else begin
        e = sb.pop_front();
        if (bus_rdata !== e.rdata || bus_err !== e.err) begin
          failures++;
          $display("FAIL resp#%0d got rdata=%h err=%b want rdata=%h err=%b",
                   e.id, bus_rdata, bus_err, e.rdata, e.err);
        end
      end
    end
  end

  // Called at a falling edge with the DUT idle; returns at a falling edge idle.
  task automatic txn(input bit we, input logic [31:0] addr, input logic [31:0] wdata,
                     input logic [3:0] strb);
    longint      e;
    exp_t        x;
    logic        err;
    logic [31:0] rd, off, t;
    logic [15:0] nps;
    e   = longint'(cyc);
    off = addr - BASE;
    err = (off >= 32'd16) || (addr[1:0] != 2'b00) || (we && strb == 4'b0000);
    rd  = 32'd0;
    if (!err && !we) begin
      case (off[3:2])
        2'd0: rd = {24'd0, m_ld};
        2'd1: rd = {24'd0, m_mask};
        2'd2: rd = {16'd0, m_ps};
        default: rd = m_tick_pre(e);
      endcase
    end
    if (!err && we) begin
      case (off[3:2])
        2'd0: if (strb[0]) m_ld = wdata[7:0];
        2'd1: if (strb[0]) m_mask = wdata[7:0];
        2'd2: begin
          t   = m_tick_pre(e);
          nps = m_ps;
          if (strb[0]) nps[7:0]  = wdata[7:0];
          if (strb[1]) nps[15:8] = wdata[15:8];
          m_tbase = t;
          m_ref   = e;
          m_ps    = nps;
        end
        default: m_tbase = -32'(tog(e));
      endcase
    end
    x.rdata = rd;
    x.err   = err;
    x.id    = ntx++;
    sb.push_back(x);
    bus_valid = 1'b1;
    bus_we    = we;
    bus_addr  = addr;
    bus_wdata = wdata;
    bus_wstrb = strb;
    @(negedge clk);
    chk("ready_latency", 32'(bus_ready), 32'd1);
    bus_valid = 1'b0;
    chk_led();
    @(negedge clk);
    chk("ready_one_cycle", 32'(bus_ready), 32'd0);
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      chk_led();
    end
  endtask

  // Wait until the next rising edge is a blink wrap edge (prescale is small).
  task automatic align_wrap();
    int guard;
    guard = 0;
    while (((longint'(cyc) - m_ref) % (longint'(m_ps) + 1) != 0) && guard < 100) begin
      @(negedge clk);
      chk_led();
      guard++;
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    bus_valid = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    m_reset();
    m_ref = longint'(cyc) - 1;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog_timeout");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
    $fatal(1);
  end

  initial begin
    bus_valid = 1'b0;
    bus_we    = 1'b0;
    bus_addr  = 32'd0;
    bus_wdata = 32'd0;
    bus_wstrb = 4'd0;
    do_reset();
    chk("reset_led", 32'(led), 32'd0);
    chk("reset_ready", 32'(bus_ready), 32'd0);

    // Defaults
    txn(0, BASE + 32'h8, 32'd0, 4'h0);
    txn(0, BASE + 32'h0, 32'd0, 4'h0);

    // Static write and readback
    txn(1, BASE + 32'h0, 32'h0000_00A5, 4'hF);
    chk("static_led", 32'(led), 32'h0000_00A5);
    txn(0, BASE + 32'h0, 32'd0, 4'h0);

    // Blink with PRESCALE=3, then tick count after ten toggles
    txn(1, BASE + 32'h0, 32'h0000_000F, 4'hF);
    txn(1, BASE + 32'h4, 32'h0000_00FF, 4'hF);
    txn(1, BASE + 32'h8, 32'h0000_0003, 4'hF);
    idle(40);
    txn(0, BASE + 32'hC, 32'd0, 4'h0);

    // Tick clear landing on a tick edge
    align_wrap();
    txn(1, BASE + 32'hC, 32'hFFFF_FFFF, 4'h4);
    txn(0, BASE + 32'hC, 32'd0, 4'h0);

    // PRESCALE write landing on a wrap edge: phase forced to 0, no tick
    idle(3);
    align_wrap();
    txn(1, BASE + 32'h8, 32'h0000_0003, 4'hF);
    chk("wrap_write_phase0", 32'(led), 32'h0000_000F);
    txn(0, BASE + 32'hC, 32'd0, 4'h0);

    // Freeze
    idle(5);
    txn(1, BASE + 32'h8, 32'h0000_0000, 4'h3);
    idle(20);

    // Errors
    txn(0, BASE + 32'h10, 32'd0, 4'h0);
    txn(1, BASE + 32'h1, 32'h0000_00FF, 4'hF);
    txn(0, BASE + 32'h0, 32'd0, 4'h0);
    txn(1, BASE + 32'h4, 32'h0000_0055, 4'h0);
    txn(0, BASE - 32'h4, 32'd0, 4'h0);

    // Byte strobes
    txn(1, BASE + 32'h0, 32'h0000_00FF, 4'hF);
    txn(1, BASE + 32'h0, 32'h0000_1200, 4'h2);
    txn(0, BASE + 32'h0, 32'd0, 4'h0);
    txn(1, BASE + 32'h8, 32'h0000_0502, 4'h1);
    txn(0, BASE + 32'h8, 32'd0, 4'h0);

    // Randomized traffic
    for (int i = 0; i < 80; i++) begin
      int          kind;
      logic [31:0] a, d;
      bit          w;
      kind = $urandom_range(0, 7);
      case (kind)
        0, 1, 2, 3: a = BASE + 32'(4 * kind);
        4:          a = BASE + 32'h10;
        5:          a = BASE - 32'h4;
        6:          a = BASE + 32'($urandom_range(1, 3)) + 32'(4 * $urandom_range(0, 3));
        default:    a = BASE + 32'(4 * $urandom_range(0, 3));
      endcase
      w = 1'($urandom_range(0, 1));
      d = $urandom;
      if (a == BASE + 32'h8) d[15:0] = 16'($urandom_range(0, 9));
      txn(w, a, d, 4'($urandom_range(0, 15)));
      idle($urandom_range(0, 6));
    end

    // Reset during RESP
    txn(1, BASE + 32'h4, 32'h0000_0000, 4'hF);
    sb.push_back('{rdata: 32'd0, err: 1'b0, id: ntx++});
    bus_valid = 1'b1;
    bus_we    = 1'b1;
    bus_addr  = BASE;
    bus_wdata = 32'h0000_003C;
    bus_wstrb = 4'hF;
    @(negedge clk);
    chk("mid_ready_before", 32'(bus_ready), 32'd1);
    chk("mid_led_before", 32'(led), 32'h0000_003C);
    #2;
    reset = 1'b1;
    bus_valid = 1'b0;
    #1;
    chk("mid_ready_dropped", 32'(bus_ready), 32'd0);
    chk("mid_led_cleared", 32'(led), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    m_reset();
    m_ref = longint'(cyc) - 1;
    txn(0, BASE + 32'h0, 32'd0, 4'h0);
    txn(0, BASE + 32'h8, 32'd0, 4'h0);
    txn(0, BASE + 32'hC, 32'd0, 4'h0);

    idle(2);
    chk("scoreboard_drained", 32'(sb.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/rv32_led_ctrl.md
# rv32_led_ctrl

Memory-mapped LED controller that acts as the responder on the priRV32 core's data bus and drives the board `led` pins. It accepts single-beat read/write requests through a valid/ready handshake and holds a static LED pattern register. A prescaled blink engine toggles a selectable subset of LEDs. A tick counter lets firmware measure elapsed blink periods.

## Interface
- `LED_WIDTH`, 8: number of LED outputs and width of the LED_DATA/BLINK_MASK fields.
- `BASE_ADDR`, 32'h1000_0000: byte address of register offset 0x0; the window is 16 bytes.
- `PRESCALE_RST`, 16'd50000: reset value of PRESCALE.
- `clk` in 1: single clock; all state changes on the rising edge.
- `reset` in 1: asynchronous, active-high reset.
- `bus_valid` in 1: request present; the master holds it and all request fields stable until `bus_ready`.
- `bus_we` in 1: 1 = write, 0 = read.
- `bus_addr` in 32: byte address.
- `bus_wdata` in 32: write data.
- `bus_wstrb` in 4: byte-lane enables for writes.
- `bus_ready` out 1: one-cycle response strobe.
- `bus_rdata` out 32: read data, valid while `bus_ready`=1.
- `bus_err` out 1: error response, valid while `bus_ready`=1.
- `led` out LED_WIDTH: registered LED drive.

## Operation
- Register map (offsets from BASE_ADDR):
  - 0x0 LED_DATA, RW, LED_WIDTH bits.
  - 0x4 BLINK_MASK, RW, LED_WIDTH bits.
  - 0x8 PRESCALE, RW, bits [15:0].
  - 0xC TICK_COUNT, RO, 32 bits. Any write clears it.
- Unused upper bits read as 0 and ignore writes.
- Byte writes honour `bus_wstrb` per lane. A TICK_COUNT write clears it regardless of strobes, but only if at least one strobe bit is set.
- Handshake FSM, 2 states:
  - IDLE: `bus_ready`=0. If `bus_valid`=1, the request is decoded and executed at this edge and the FSM moves to RESP.
  - RESP: `bus_ready`=1 for exactly one cycle with `bus_rdata`/`bus_err`. `bus_valid` is ignored in this cycle. The FSM always returns to IDLE.
  - Maximum throughput is one transaction per 2 cycles.
- Error response (`bus_err`=1, `bus_rdata`=0, no state change) on any of:
  - address outside [BASE_ADDR, BASE_ADDR+0xF];
  - `bus_addr[1:0]` not equal to 0;
  - a write with `bus_wstrb`=0.
- Read data is sampled at the capture edge and held in `bus_rdata` through RESP. It returns to 0 in IDLE.
- Blink engine:
  - A 16-bit down-counter `cnt` and a `phase` bit.
  - If PRESCALE=0: `cnt` and `phase` hold and no ticks occur.
  - Otherwise `cnt` decrements each cycle. On the edge where `cnt`=0: reload `cnt`=PRESCALE, toggle `phase`, and increment TICK_COUNT.
  - TICK_COUNT wraps 32'hFFFF_FFFF -> 0.
- `led` register next-value = LED_DATA_next ^ (BLINK_MASK_next & {LED_WIDTH{phase_next}}).
- Simultaneous events:
  - PRESCALE write on a wrap edge: the write wins. `cnt` is loaded with the new value, `phase` is forced to 0, and there is no tick.
  - Any PRESCALE write, at any time, reloads `cnt` and clears `phase`.
  - TICK_COUNT clear on a tick edge: the result is 0.
  - Read of TICK_COUNT on a tick edge returns the pre-increment value.
- Reset values:
  - FSM=IDLE, `bus_ready`=0, `bus_rdata`=0, `bus_err`=0, `led`=0.
  - LED_DATA=0, BLINK_MASK=0, PRESCALE=PRESCALE_RST, `cnt`=PRESCALE_RST, `phase`=0, TICK_COUNT=0.
- Reset mid-transaction: the response is dropped and `bus_ready` does not assert. The master must reissue the request.

## Timing
- Request sampled at edge N → `bus_ready`=1 during cycle N..N+1 → deasserted after edge N+1.
- A write takes effect at edge N. `led` reflects the new LED_DATA/BLINK_MASK from edge N, i.e. in the same cycle `bus_ready` is high.
- Blink toggle period is PRESCALE+1 cycles. A full on/off period is 2·(PRESCALE+1) cycles.
- After a PRESCALE write of P at edge N, the first toggle occurs at edge N+P+1.
- All outputs are registered; there is no combinational path from inputs to outputs.

## Test plan
- Reset/defaults: assert `reset` for 2 cycles, release → `led`=0, `bus_ready`=0. Read 0x8 returns 50000 (default `PRESCALE_RST`=16'd50000). Read 0x0 returns 0.
- Static write: write 0x0 = 32'h0000_00A5 with wstrb=4'hF → `bus_ready` exactly one cycle after valid, `bus_err`=0, `led`=8'hA5 in the ready cycle. Readback returns 32'h0000_00A5.
- Blink:
  - Setup: LED_DATA=8'h0F, BLINK_MASK=8'hFF, PRESCALE=3.
  - `led` alternates 8'h0F ↔ 8'hF0 every 4 cycles.
  - After 10 toggles, TICK_COUNT reads 10.
  - Write PRESCALE=0 → `led` freezes.
- Errors: read BASE_ADDR+0x10 → `bus_err`=1, `bus_rdata`=0. A misaligned write to 0x1 returns `bus_err`=1, and LED_DATA remains unchanged.
- Byte strobes: LED_DATA=8'hFF, then write 32'h0000_1200 with wstrb=4'h2 → LED_DATA stays 8'hFF. Any write with wstrb=0 → `bus_err`=1.
- Collisions/reset:
  - TICK_COUNT clear on a tick edge reads back 0.
  - A PRESCALE write on a wrap edge yields `phase`=0.
  - `reset` asserted during RESP → `bus_ready` drops immediately and all registers return to their defaults.
